// File: rtl/fifo_arb_n.sv
// N-channel framed byte-stream arbiter: demultiplexes inbound frames by header channel and
// merges outbound client frames round-robin. Define FIFO_ARB_N_STATS_EN to enable drop_cnt.
module fifo_arb_n #(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic            CLK,
    input  logic            RESETn,
    output logic            com_rden,
    input  logic            com_rdempty,
    input  logic [DW-1:0]   com_rddata,
    output logic            com_wren,
    input  logic            com_wrfull,
    output logic [DW-1:0]   com_wrdata,
    input  logic [N-1:0]    c_rden,
    output logic [N-1:0]    c_rdempty,
    output logic [N*DW-1:0] c_rddata,
    input  logic [N-1:0]    c_wren,
    output logic [N-1:0]    c_wrfull,
    input  logic [N*DW-1:0] c_wrdata,
    output logic [15:0]     drop_cnt
);
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam int LW    = DW - CW;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {RX_HDR, RX_DATA, RX_DROP} rx_state_e;
    typedef enum logic {TX_IDLE, TX_DATA} tx_state_e;

    logic [N-1:0]  rx_push, rx_full, tx_pop, tx_empty;
    logic [DW-1:0] tx_head [N];

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [DW-1:0] rx_mem [DEPTH];
        logic [DW-1:0] tx_mem [DEPTH];
        logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
        logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
        logic [AW:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
        logic          rx_we, rx_re, tx_we, tx_re;

        // NOTE: combinational blocks use blocking '=' and registers use '<=' so each flop
        // samples a settled next-state value without simulation ordering races.
        always_comb begin
            rx_we    = rx_push[i] && !rx_full[i];
            rx_re    = c_rden[i] && !c_rdempty[i];
            tx_we    = c_wren[i] && !c_wrfull[i];
            tx_re    = tx_pop[i] && !tx_empty[i];
            rx_wp_d  = rx_wp_q + AW'(rx_we);
            rx_rp_d  = rx_rp_q + AW'(rx_re);
            rx_cnt_d = rx_cnt_q + (AW+1)'(rx_we) - (AW+1)'(rx_re);
            tx_wp_d  = tx_wp_q + AW'(tx_we);
            tx_rp_d  = tx_rp_q + AW'(tx_re);
            tx_cnt_d = tx_cnt_q + (AW+1)'(tx_we) - (AW+1)'(tx_re);
        end

        always_ff @(posedge CLK or negedge RESETn) begin
            if (!RESETn) begin
                rx_wp_q  <= '0;
                rx_rp_q  <= '0;
                rx_cnt_q <= '0;
                tx_wp_q  <= '0;
                tx_rp_q  <= '0;
                tx_cnt_q <= '0;
            end else begin
                rx_wp_q  <= rx_wp_d;
                rx_rp_q  <= rx_rp_d;
                rx_cnt_q <= rx_cnt_d;
                tx_wp_q  <= tx_wp_d;
                tx_rp_q  <= tx_rp_d;
                tx_cnt_q <= tx_cnt_d;
            end
        end

        // NOTE: storage arrays carry no reset; the occupancy counters alone define validity.
        always_ff @(posedge CLK) begin
            if (rx_we) rx_mem[rx_wp_q] <= com_rddata;
            if (tx_we) tx_mem[tx_wp_q] <= c_wrdata[i*DW +: DW];
        end

        assign rx_full[i]            = (rx_cnt_q == (AW+1)'(DEPTH));
        assign c_rdempty[i]          = (rx_cnt_q == '0);
        assign c_wrfull[i]           = (tx_cnt_q == (AW+1)'(DEPTH));
        assign tx_empty[i]           = (tx_cnt_q == '0);
        assign c_rddata[i*DW +: DW]  = c_rdempty[i] ? '0 : rx_mem[rx_rp_q];
        assign tx_head[i]            = tx_mem[tx_rp_q];
    end

    // ---------------- inbound demultiplexer ----------------
    rx_state_e     rx_state_q, rx_state_d;
    logic [LW-1:0] rx_rem_q, rx_rem_d;
    logic [CW-1:0] rx_ch_q, rx_ch_d;
    logic [CW-1:0] hdr_ch;
    logic [LW-1:0] hdr_len;
    logic          hdr_valid;

    assign hdr_ch    = com_rddata[DW-1:LW];
    assign hdr_len   = com_rddata[LW-1:0];
    assign hdr_valid = ({1'b0, hdr_ch} < (CW+1)'(N));

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            rx_state_q <= RX_HDR;
            rx_rem_q   <= '0;
            rx_ch_q    <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_rem_q   <= rx_rem_d;
            rx_ch_q    <= rx_ch_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        rx_state_d = rx_state_q;
        rx_rem_d   = rx_rem_q;
        rx_ch_d    = rx_ch_q;
        if (com_rden) begin
            if (rx_state_q == RX_HDR) begin
                rx_ch_d  = hdr_ch;
                rx_rem_d = hdr_len;
                if (hdr_len != '0) rx_state_d = hdr_valid ? RX_DATA : RX_DROP;
            end else begin
                rx_rem_d = rx_rem_q - 1'b1;
                if (rx_rem_q == LW'(1)) rx_state_d = RX_HDR;
            end
        end
    end

    // Transport strobes are gated by reset so they read 0 the moment RESETn falls.
    always_comb begin
        com_rden = 1'b0;
        rx_push  = '0;
        if (RESETn && !com_rdempty) begin
            unique case (rx_state_q)
                RX_HDR: begin
                    if (!hdr_valid) begin
                        com_rden = 1'b1;
                    end else if (!rx_full[hdr_ch]) begin
                        com_rden        = 1'b1;
                        rx_push[hdr_ch] = 1'b1;
                    end
                end
                RX_DATA: begin
                    if (!rx_full[rx_ch_q]) begin
                        com_rden         = 1'b1;
                        rx_push[rx_ch_q] = 1'b1;
                    end
                end
                RX_DROP: com_rden = 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- outbound round-robin merger ----------------
    tx_state_e     tx_state_q, tx_state_d;
    logic [LW-1:0] tx_rem_q, tx_rem_d;
    logic [CW-1:0] tx_ch_q, tx_ch_d, last_q, last_d, gnt_idx;
    logic          gnt_found;

    // Scan starts just after the last granted client, wrapping at N.
    always_comb begin
        logic [CW-1:0] scan;
        gnt_found = 1'b0;
        gnt_idx   = last_q;
        scan      = last_q;
        for (int k = 0; k < N; k++) begin
            scan = (scan == CW'(N-1)) ? '0 : scan + 1'b1;
            if (!gnt_found && !tx_empty[scan]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            tx_state_q <= TX_IDLE;
            tx_rem_q   <= '0;
            tx_ch_q    <= '0;
            last_q     <= CW'(N-1);
        end else begin
            tx_state_q <= tx_state_d;
            tx_rem_q   <= tx_rem_d;
            tx_ch_q    <= tx_ch_d;
            last_q     <= last_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_rem_d   = tx_rem_q;
        tx_ch_d    = tx_ch_q;
        last_d     = last_q;
        if (com_wren) begin
            if (tx_state_q == TX_IDLE) begin
                tx_ch_d  = gnt_idx;
                tx_rem_d = tx_head[gnt_idx][LW-1:0];
                if (tx_head[gnt_idx][LW-1:0] != '0) tx_state_d = TX_DATA;
                else                                last_d     = gnt_idx;
            end else begin
                tx_rem_d = tx_rem_q - 1'b1;
                if (tx_rem_q == LW'(1)) begin
                    tx_state_d = TX_IDLE;
                    last_d     = tx_ch_q;
                end
            end
        end
    end

    always_comb begin
        com_wren   = 1'b0;
        com_wrdata = '0;
        tx_pop     = '0;
        if (RESETn && !com_wrfull) begin
            unique case (tx_state_q)
                TX_IDLE: begin
                    if (gnt_found) begin
                        com_wren        = 1'b1;
                        tx_pop[gnt_idx] = 1'b1;
                        com_wrdata      = {gnt_idx, tx_head[gnt_idx][LW-1:0]};
                    end
                end
                TX_DATA: begin
                    if (!tx_empty[tx_ch_q]) begin
                        com_wren        = 1'b1;
                        tx_pop[tx_ch_q] = 1'b1;
                        com_wrdata      = tx_head[tx_ch_q];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_ARB_N_STATS_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (com_rden && rx_state_q == RX_HDR && !hdr_valid && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) drop_q <= '0;
        else         drop_q <= drop_d;
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_arb_n.sv
// Directed bench for fifo_arb_n (N=3, DW=8, AW=3): vector tables for inbound demux and
// outbound merge plus hand sequences for stalls, round-robin, buffer limits and reset.
module tb_fifo_arb_n;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int AW = 3;

    logic            CLK, RESETn;
    logic            com_rden, com_rdempty, com_wren, com_wrfull;
    logic [DW-1:0]   com_rddata, com_wrdata;
    logic [N-1:0]    c_rden, c_rdempty, c_wren, c_wrfull;
    logic [N*DW-1:0] c_rddata, c_wrdata;
    logic [15:0]     drop_cnt;

    fifo_arb_n #(.N(N), .DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .com_rden(com_rden), .com_rdempty(com_rdempty), .com_rddata(com_rddata),
        .com_wren(com_wren), .com_wrfull(com_wrfull), .com_wrdata(com_wrdata),
        .c_rden(c_rden), .c_rdempty(c_rdempty), .c_rddata(c_rddata),
        .c_wren(c_wren), .c_wrfull(c_wrfull), .c_wrdata(c_wrdata),
        .drop_cnt(drop_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] b;
        int         ch;
    } rx_vec_t;

    typedef struct {
        logic [2:0] wren;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] exp_out;
    } tx_vec_t;

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] in_q[$];
    logic [7:0] out_q[$];
    int         out_cyc[$];
    logic [7:0] exp_drop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_at(input int i);
        return (i < out_q.size()) ? 32'(out_q[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic refresh_in();
        com_rdempty = (in_q.size() == 0);
        com_rddata  = (in_q.size() != 0) ? in_q[0] : 8'h00;
    endtask

    // One clock: sample strobes before the edge, update transport models at it, realign after.
    task automatic tick();
        logic s_rden, s_wren;
        logic [7:0] s_wdata;
        #2;
        s_rden  = com_rden;
        s_wren  = com_wren;
        s_wdata = com_wrdata;
        @(posedge CLK);
        if (s_rden && in_q.size() != 0) void'(in_q.pop_front());
        if (s_wren) begin
            out_q.push_back(s_wdata);
            out_cyc.push_back(cyc);
        end
        cyc++;
        @(negedge CLK);
        refresh_in();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cwrite(input logic [2:0] en, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2);
        c_wren   = en;
        c_wrdata = {d2, d1, d0};
        tick();
        c_wren   = '0;
    endtask

    task automatic cread(input int ch, input logic [7:0] exp, input string name);
        check({name, " not empty"}, 32'(c_rdempty[ch]), 32'd0);
        check(name, 32'(c_rddata[ch*8 +: 8]), 32'(exp));
        c_rden[ch] = 1'b1;
        tick();
        c_rden = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " com_rden"}, 32'(com_rden), 32'd0);
        check({tag, " com_wren"}, 32'(com_wren), 32'd0);
        check({tag, " com_wrdata"}, 32'(com_wrdata), 32'd0);
        check({tag, " c_rdempty"}, 32'(c_rdempty), 32'b111);
        check({tag, " c_wrfull"}, 32'(c_wrfull), 32'd0);
        check({tag, " c_rddata"}, 32'(c_rddata), 32'd0);
        check({tag, " drop_cnt"}, 32'(drop_cnt), 32'd0);
    endtask

    task automatic do_reset();
        c_rden     = '0;
        c_wren     = '0;
        c_wrdata   = '0;
        com_wrfull = 1'b0;
        in_q.delete();
        refresh_in();
        @(negedge CLK);
        RESETn = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge CLK);
        RESETn = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rx_vec_t rx_tab [12];
        tx_vec_t tx_tab [5];
        int      c0, base;
        logic [7:0] rr_exp [6];

        rx_tab = '{'{8'h43, 1}, '{8'hA1, 1}, '{8'hA2, 1}, '{8'hA3, 1},
                   '{8'hC2, -1}, '{8'h55, -1}, '{8'h66, -1}, '{8'h00, 0},
                   '{8'hC0, -1}, '{8'h82, 2}, '{8'h5A, 2}, '{8'hA5, 2}};
        tx_tab = '{'{3'b101, 8'h02, 8'h00, 8'h01, 8'h02},
                   '{3'b101, 8'h11, 8'h00, 8'h33, 8'h11},
                   '{3'b001, 8'h22, 8'h00, 8'h00, 8'h22},
                   '{3'b000, 8'h00, 8'h00, 8'h00, 8'h81},
                   '{3'b000, 8'h00, 8'h00, 8'h00, 8'h33}};
        rr_exp = '{8'h00, 8'h40, 8'h80, 8'h00, 8'h40, 8'h80};
`ifdef FIFO_ARB_N_STATS_EN
        exp_drop = 8'd2;
`else
        exp_drop = 8'd0;
`endif

        RESETn = 1'b1;
        do_reset();

        // Round-robin over zero-length headers; client channel bits C0 get overwritten.
        com_wrfull = 1'b1;
        out_q.delete();
        out_cyc.delete();
        cwrite(3'b111, 8'hC0, 8'hC0, 8'hC0);
        cwrite(3'b111, 8'hC0, 8'hC0, 8'hC0);
        check("rr held by wrfull", 32'(out_q.size()), 32'd0);
        com_wrfull = 1'b0;
        ticks(8);
        check("rr count", 32'(out_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) check($sformatf("rr grant %0d", i), out_at(i), 32'(rr_exp[i]));
        if (out_cyc.size() == 6) check("rr contiguous", 32'(out_cyc[5] - out_cyc[0]), 32'd5);

        // Outbound merge table: two clients write in the same cycles.
        out_q.delete();
        out_cyc.delete();
        c0 = cyc;
        foreach (tx_tab[i]) cwrite(tx_tab[i].wren, tx_tab[i].d0, tx_tab[i].d1, tx_tab[i].d2);
        ticks(3);
        check("tx count", 32'(out_q.size()), 32'd5);
        foreach (tx_tab[i]) check($sformatf("tx byte %0d", i), out_at(i), 32'(tx_tab[i].exp_out));
        if (out_cyc.size() == 5) begin
            check("tx first latency", 32'(out_cyc[0] - c0), 32'd1);
            check("tx contiguous", 32'(out_cyc[4] - out_cyc[0]), 32'd4);
        end

        // Outbound back-pressure for 10 cycles mid-frame.
        out_q.delete();
        cwrite(3'b010, 8'h00, 8'h44, 8'h00);
        cwrite(3'b010, 8'h00, 8'hB1, 8'h00);
        tick();
        check("stall pre count", 32'(out_q.size()), 32'd2);
        com_wrfull = 1'b1;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (k < 3) begin
                c_wren   = 3'b010;
                c_wrdata = {8'h00, 8'(8'hB2 + k), 8'h00};
            end
            check($sformatf("stall wren %0d", k), 32'(com_wren), 32'd0);
            tick();
            c_wren = '0;
        end
        com_wrfull = 1'b0;
        ticks(7);
        check("stall count", 32'(out_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("stall byte %0d", i), out_at(i), (i == 0) ? 32'h44 : 32'(8'hB0 + i));

        // Client tx buffer fills at 8 entries; the 9th push is ignored.
        out_q.delete();
        com_wrfull = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cwrite(3'b001, (k == 0) ? 8'h07 : 8'(8'hF0 + k), 8'h00, 8'h00);
            if (k == 6) check("wrfull at 7", 32'(c_wrfull), 32'd0);
        end
        check("wrfull at 8", 32'(c_wrfull), 32'b001);
        cwrite(3'b001, 8'hEE, 8'h00, 8'h00);
        check("wrfull after overflow", 32'(c_wrfull), 32'b001);
        com_wrfull = 1'b0;
        ticks(12);
        check("full drain count", 32'(out_q.size()), 32'd8);
        check("full drain first", out_at(0), 32'h07);
        check("full drain last", out_at(7), 32'hF7);
        check("wrfull cleared", 32'(c_wrfull), 32'd0);

        // Inbound latency: pop in cycle k, visible to the client in cycle k+1.
        in_q.push_back(8'h40);
        refresh_in();
        #1;
        check("rx pop strobe", 32'(com_rden), 32'd1);
        tick();
        check("rx visible next", 32'(c_rdempty), 32'b101);
        cread(1, 8'h40, "rx latency byte");

        // Inbound demux table: client 1 frame alone, then drops and frames for 0 and 2.
        for (int i = 0; i < 4; i++) in_q.push_back(rx_tab[i].b);
        refresh_in();
        ticks(6);
        check("rx only client 1", 32'(c_rdempty), 32'b101);
        for (int i = 4; i < 12; i++) in_q.push_back(rx_tab[i].b);
        refresh_in();
        ticks(12);
        check("rx all delivered", 32'(c_rdempty), 32'b000);
        check("rx source drained", 32'(in_q.size()), 32'd0);
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        for (int c = 0; c < N; c++)
            foreach (rx_tab[i])
                if (rx_tab[i].ch == c) cread(c, rx_tab[i].b, $sformatf("rx vec %0d", i));
        check("rx all read", 32'(c_rdempty), 32'b111);

        // Head-of-line: client 1 buffer fills, client 2 frame waits behind it.
        in_q.push_back(8'h48);
        for (int k = 0; k < 8; k++) in_q.push_back(8'(8'hD0 + k));
        in_q.push_back(8'h81);
        in_q.push_back(8'h99);
        refresh_in();
        ticks(15);
        check("hol rdempty", 32'(c_rdempty), 32'b101);
        check("hol source left", 32'(in_q.size()), 32'd3);
        check("hol rden low", 32'(com_rden), 32'd0);
        cread(1, 8'h48, "hol hdr");
        for (int k = 0; k < 8; k++) cread(1, 8'(8'hD0 + k), $sformatf("hol data %0d", k));
        ticks(2);
        cread(2, 8'h81, "hol c2 hdr");
        cread(2, 8'h99, "hol c2 data");

        // Reset in the middle of an inbound and an outbound frame.
        do_reset();
        out_q.delete();
        in_q.push_back(8'h44);
        in_q.push_back(8'hD1);
        in_q.push_back(8'hD2);
        refresh_in();
        cwrite(3'b100, 8'h00, 8'h00, 8'h82);
        cwrite(3'b100, 8'h00, 8'h00, 8'hE1);
        ticks(4);
        check("mid tx count", 32'(out_q.size()), 32'd2);
        check("mid tx hdr", out_at(0), 32'h82);
        base = out_q.size();
        RESETn = 1'b0;
        in_q.delete();
        in_q.push_back(8'h41);
        in_q.push_back(8'h77);
        refresh_in();
        #1;
        check_reset_outputs("mid reset");
        @(negedge CLK);
        RESETn = 1'b1;
        #1;
        ticks(4);
        cread(1, 8'h41, "post reset hdr");
        cread(1, 8'h77, "post reset data");
        check("post reset c0 c2 empty", 32'({c_rdempty[2], c_rdempty[0]}), 32'b11);
        check("post reset no tx", 32'(out_q.size()), 32'(base));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
